// File: rtl/acc_dma_if.sv
// acc_dma_if: 32-bit valid/ready memory-bus bundle.
//   valid/addr/wdata/wstrb : request from the initiator (wstrb == 0 means read)
//   ready/rdata            : acknowledge and read data from the target
// The master modport is the initiating side, the slave modport the responding side.
interface acc_dma_if;
  logic        valid;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        ready;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input  ready, rdata);
  modport slave  (input  valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/acc_dma.sv
// acc_dma: bus-master sequencer for the matmul accelerator.
//   clk, resetn : clock, synchronous active-low reset
//   s_bus       : CPU register window (SRC +0, DST +4, CTRL/STATUS +8 at ADDR_CTRL)
//   m_bus       : master port to RAM and the accelerator windows
//   busy        : job in progress (also STATUS bit0)
// A job copies NLD input words SRC -> accelerator write window, then moves NRS result
// words to DST, optionally adding lane-wise into the existing DST contents.
module acc_dma #(
  parameter logic [31:0] ADDR_CTRL      = 32'h0160_0000,
  parameter logic [31:0] ACC_ADDR_WRITE = 32'h0110_0000,
  parameter logic [31:0] ACC_ADDR_READ  = 32'h0130_0000,
  parameter int unsigned R              = 8,
  parameter int unsigned S              = 8,
  parameter int unsigned INPUT_WIDTH    = 8,
  parameter int unsigned RESULT_WIDTH   = 16
) (
  input  logic      clk,
  input  logic      resetn,
  acc_dma_if.slave  s_bus,
  acc_dma_if.master m_bus,
  output logic      busy
);
  localparam int unsigned NLD   = (R + R * S) * INPUT_WIDTH / 32;
  localparam int unsigned NRS   = S * RESULT_WIDTH / 32;
  localparam int unsigned LANES = 32 / RESULT_WIDTH;
  localparam int unsigned IW    = $clog2((NLD > NRS ? NLD : NRS) + 1);
  localparam logic [IW-1:0] LAST_LD = IW'(NLD - 1);
  localparam logic [IW-1:0] LAST_RS = IW'(NRS - 1);

  typedef enum logic [2:0] {IDLE, LD_RD, LD_WR, RS_RD, DS_RD, DS_WR} state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   src_q, src_d, dst_q, dst_d;
  logic          acc_q, acc_d, done_q, done_d;
  logic [31:0]   buf_q, buf_d, res_q, res_d;
  logic          mem_ready_q, mem_ready_d;
  logic [31:0]   mem_rdata_q, mem_rdata_d;
  logic          m_valid_q, m_valid_d;
  logic [31:0]   m_addr_q, m_addr_d, m_wdata_q, m_wdata_d;
  logic [3:0]    m_wstrb_q, m_wstrb_d;

  logic          ack, start, s_accept, s_hit;
  logic [31:0]   s_off, beat_off;

  assign ack      = m_valid_q & m_bus.ready;
  assign beat_off = {{(30 - IW){1'b0}}, idx_q, 2'b00};

  assign s_bus.ready = mem_ready_q;
  assign s_bus.rdata = mem_rdata_q;
  assign m_bus.valid = m_valid_q;
  assign m_bus.addr  = m_addr_q;
  assign m_bus.wdata = m_wdata_q;
  assign m_bus.wstrb = m_wstrb_q;

  function automatic logic [31:0] lane_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = '0;
    for (int unsigned l = 0; l < LANES; l++)
      s[l*RESULT_WIDTH +: RESULT_WIDTH] = a[l*RESULT_WIDTH +: RESULT_WIDTH] + b[l*RESULT_WIDTH +: RESULT_WIDTH];
    return s;
  endfunction

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      src_q       <= '0;
      dst_q       <= '0;
      acc_q       <= 1'b0;
      done_q      <= 1'b0;
      buf_q       <= '0;
      res_q       <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
      m_valid_q   <= 1'b0;
      m_addr_q    <= '0;
      m_wdata_q   <= '0;
      m_wstrb_q   <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      src_q       <= src_d;
      dst_q       <= dst_d;
      acc_q       <= acc_d;
      done_q      <= done_d;
      buf_q       <= buf_d;
      res_q       <= res_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
      m_valid_q   <= m_valid_d;
      m_addr_q    <= m_addr_d;
      m_wdata_q   <= m_wdata_d;
      m_wstrb_q   <= m_wstrb_d;
    end
  end

  // Register window; the unsigned offset compare rejects addresses below the base too.
  always_comb begin
    s_off       = s_bus.addr - ADDR_CTRL;
    s_hit       = (s_off < 32'd12);
    s_accept    = s_bus.valid & ~mem_ready_q & s_hit;
    start       = 1'b0;
    src_d       = src_q;
    dst_d       = dst_q;
    acc_d       = acc_q;
    mem_ready_d = s_accept;
    mem_rdata_d = mem_rdata_q;
    if (s_accept) begin
      if (s_bus.wstrb == 4'h0) begin
        case (s_off[3:2])
          2'd0:    mem_rdata_d = src_q;
          2'd1:    mem_rdata_d = dst_q;
          2'd2:    mem_rdata_d = {29'b0, acc_q, done_q, state_q != IDLE};
          default: mem_rdata_d = '0;
        endcase
      end else if (state_q == IDLE) begin
        case (s_off[3:2])
          2'd0: begin
            for (int unsigned b = 0; b < 4; b++)
              if (s_bus.wstrb[b]) src_d[8*b +: 8] = s_bus.wdata[8*b +: 8];
            src_d[1:0] = 2'b00;
          end
          2'd1: begin
            for (int unsigned b = 0; b < 4; b++)
              if (s_bus.wstrb[b]) dst_d[8*b +: 8] = s_bus.wdata[8*b +: 8];
            dst_d[1:0] = 2'b00;
          end
          2'd2: begin
            if (s_bus.wstrb[0]) begin
              acc_d = s_bus.wdata[1];
              start = s_bus.wdata[0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE:  if (start) begin state_d = LD_RD; idx_d = '0; end
      LD_RD: if (ack) state_d = LD_WR;
      LD_WR: if (ack) begin
        if (idx_q == LAST_LD) begin state_d = RS_RD; idx_d = '0; end
        else begin state_d = LD_RD; idx_d = idx_q + 1'b1; end
      end
      RS_RD: if (ack) state_d = acc_q ? DS_RD : DS_WR;
      DS_RD: if (ack) state_d = DS_WR;
      DS_WR: if (ack) begin
        if (idx_q == LAST_RS) state_d = IDLE;
        else begin state_d = RS_RD; idx_d = idx_q + 1'b1; end
      end
      default: state_d = IDLE;
    endcase
  end

  // A beat is launched only from a cycle where m_valid is low, so the cycle right
  // after every ack is idle and the next request follows one cycle later.
  always_comb begin
    busy      = (state_q != IDLE);
    m_valid_d = m_valid_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_wstrb_d = m_wstrb_q;
    buf_d     = buf_q;
    res_d     = res_q;
    done_d    = done_q;
    if (start) done_d = 1'b0;
    if (ack) begin
      m_valid_d = 1'b0;
      case (state_q)
        LD_RD, DS_RD: buf_d = m_bus.rdata;
        RS_RD:        res_d = m_bus.rdata;
        DS_WR:        if (idx_q == LAST_RS) done_d = 1'b1;
        default: ;
      endcase
    end else if (!m_valid_q && state_q != IDLE) begin
      m_valid_d = 1'b1;
      case (state_q)
        LD_RD: begin m_addr_d = src_q + beat_off;          m_wstrb_d = 4'h0; end
        LD_WR: begin m_addr_d = ACC_ADDR_WRITE + beat_off; m_wstrb_d = 4'hF; m_wdata_d = buf_q; end
        RS_RD: begin m_addr_d = ACC_ADDR_READ + beat_off;  m_wstrb_d = 4'h0; end
        DS_RD: begin m_addr_d = dst_q + beat_off;          m_wstrb_d = 4'h0; end
        DS_WR: begin
          m_addr_d  = dst_q + beat_off;
          m_wstrb_d = 4'hF;
          m_wdata_d = acc_q ? lane_add(res_q, buf_q) : res_q;
        end
        default: m_valid_d = 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_dma.sv
// tb_acc_dma: directed + randomized bench for acc_dma with a RAM/accelerator responder.
`timescale 1ns/1ps
module tb_acc_dma;
  localparam logic [31:0] ADDR_CTRL = 32'h0160_0000;
  localparam logic [31:0] ACC_W     = 32'h0110_0000;
  localparam logic [31:0] ACC_R     = 32'h0130_0000;
  localparam int NLD = 18;
  localparam int NRS = 4;

  typedef struct packed { logic we; logic [31:0] addr; logic [31:0] data; } beat_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic busy;
  acc_dma_if sb();
  acc_dma_if mb();

  acc_dma dut (.clk(clk), .resetn(resetn), .s_bus(sb), .m_bus(mb), .busy(busy));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [31:0] ram [bit [31:0]];
  logic [31:0] acc_buf [NLD];
  beat_t log_q[$];
  beat_t exp_q[$];
  logic [31:0] exp_dst [NRS];
  int max_lat = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rd_ram(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : 32'h0;
  endfunction

  function automatic beat_t mk(input logic we, input logic [31:0] a, input logic [31:0] d);
    beat_t b;
    b.we = we; b.addr = a; b.data = d;
    return b;
  endfunction

  // Reference matmul: element stream is A[0..R-1] then B column-major, bytes little-endian
  // within words; result lane c = sum_r A[r]*B[r][c] mod 2^16, two lanes per word.
  function automatic logic [31:0] mm_word(input logic [31:0] w [NLD], input int j);
    logic [7:0]  b [NLD*4];
    logic [31:0] res;
    int sum, c;
    for (int k = 0; k < NLD*4; k++) b[k] = w[k/4][8*(k%4) +: 8];
    res = 32'h0;
    for (int l = 0; l < 2; l++) begin
      c = 2*j + l;
      sum = 0;
      for (int r = 0; r < 8; r++) sum += int'(b[r]) * int'(b[8 + c*8 + r]);
      res[16*l +: 16] = sum[15:0];
    end
    return res;
  endfunction

  // RAM + accelerator responder with random ready latency; also checks protocol rules.
  bit          rsp_pend = 1'b0;
  int          rsp_lat = 0;
  logic [31:0] rsp_addr, rsp_d;
  always @(negedge clk) begin
    if (!resetn) begin
      mb.ready = 1'b0;
      mb.rdata = '0;
      rsp_pend = 1'b0;
      rsp_lat  = 0;
    end else if (mb.ready) begin
      mb.ready = 1'b0;
      check("idle_gap", {63'b0, mb.valid}, 64'd0);
    end else if (mb.valid) begin
      if (!rsp_pend) begin
        rsp_pend = 1'b1;
        rsp_addr = mb.addr;
        rsp_lat  = int'($urandom_range(max_lat));
      end else begin
        check("addr_stable", mb.addr, rsp_addr);
      end
      if (rsp_lat == 0) begin
        if (mb.wstrb != 4'h0) begin
          check("wstrb", mb.wstrb, 4'hF);
          if (mb.addr - ACC_W < 32'(4*NLD)) acc_buf[int'((mb.addr - ACC_W) >> 2)] = mb.wdata;
          else ram[mb.addr] = mb.wdata;
          log_q.push_back(mk(1'b1, mb.addr, mb.wdata));
        end else begin
          if (mb.addr - ACC_R < 32'(4*NRS)) rsp_d = mm_word(acc_buf, int'((mb.addr - ACC_R) >> 2));
          else rsp_d = rd_ram(mb.addr);
          mb.rdata = rsp_d;
          log_q.push_back(mk(1'b0, mb.addr, rsp_d));
        end
        mb.ready = 1'b1;
        rsp_pend = 1'b0;
      end else begin
        rsp_lat--;
      end
    end
  end

  task automatic cpu_access(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            output logic [31:0] rd, output bit ok);
    @(negedge clk);
    sb.valid = 1'b1; sb.addr = a; sb.wdata = d; sb.wstrb = s;
    ok = 1'b0; rd = '0;
    for (int k = 0; k < 8 && !ok; k++) begin
      @(negedge clk);
      if (sb.ready === 1'b1) begin ok = 1'b1; rd = sb.rdata; end
    end
    sb.valid = 1'b0; sb.wstrb = 4'h0;
  endtask

  task automatic cpu_wr(input string tag, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] rd;
    bit ok;
    cpu_access(a, d, 4'hF, rd, ok);
    check({tag, "_wr_ack"}, 64'(ok), 64'd1);
  endtask

  task automatic cpu_rd(input string tag, input logic [31:0] a, output logic [31:0] d);
    bit ok;
    cpu_access(a, 32'h0, 4'h0, d, ok);
    check({tag, "_rd_ack"}, 64'(ok), 64'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 5000) begin @(negedge clk); n++; end
    check({tag, "_done_in_time"}, 64'(n < 5000), 64'd1);
  endtask

  task automatic prepare(input logic [31:0] src, input logic [31:0] dst, input bit acc);
    logic [31:0] ldw [NLD];
    logic [31:0] r, old;
    exp_q.delete();
    log_q.delete();
    for (int i = 0; i < NLD; i++) begin
      ldw[i] = rd_ram(src + 32'(4*i));
      exp_q.push_back(mk(1'b0, src + 32'(4*i), ldw[i]));
      exp_q.push_back(mk(1'b1, ACC_W + 32'(4*i), ldw[i]));
    end
    for (int j = 0; j < NRS; j++) begin
      r = mm_word(ldw, j);
      exp_q.push_back(mk(1'b0, ACC_R + 32'(4*j), r));
      if (acc) begin
        old = rd_ram(dst + 32'(4*j));
        exp_q.push_back(mk(1'b0, dst + 32'(4*j), old));
        r = {16'(r[31:16] + old[31:16]), 16'(r[15:0] + old[15:0])};
      end
      exp_q.push_back(mk(1'b1, dst + 32'(4*j), r));
      exp_dst[j] = r;
    end
  endtask

  task automatic verify(input string tag, input logic [31:0] dst, input bit acc);
    logic [31:0] st;
    check({tag, "_nbeats"}, 64'(log_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check({tag, "_beat_kind_addr"}, {31'b0, log_q[i].we, log_q[i].addr}, {31'b0, exp_q[i].we, exp_q[i].addr});
      check({tag, "_beat_data"}, log_q[i].data, exp_q[i].data);
    end
    for (int j = 0; j < NRS; j++) check({tag, "_dst"}, rd_ram(dst + 32'(4*j)), exp_dst[j]);
    check({tag, "_busy_end"}, 64'(busy), 64'd0);
    cpu_rd({tag, "_status"}, ADDR_CTRL + 8, st);
    check({tag, "_status"}, st, {29'b0, acc, 1'b1, 1'b0});
  endtask

  task automatic run_job(input string tag, input logic [31:0] src, input logic [31:0] dst, input bit acc);
    cpu_wr({tag, "_src"}, ADDR_CTRL, src);
    cpu_wr({tag, "_dst"}, ADDR_CTRL + 4, dst);
    prepare(src, dst, acc);
    cpu_wr({tag, "_ctrl"}, ADDR_CTRL + 8, {30'b0, acc, 1'b1});
    wait_idle(tag);
    verify(tag, dst, acc);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    bit ok;
    int n;
    logic [31:0] src, dst;

    // 1: reset held with a pending slave request
    resetn = 1'b0;
    sb.valid = 1'b1; sb.addr = ADDR_CTRL + 8; sb.wdata = '0; sb.wstrb = 4'h0;
    repeat (4) @(negedge clk);
    check("rst_mem_ready", 64'(sb.ready), 64'd0);
    check("rst_mem_rdata", sb.rdata, 64'd0);
    check("rst_m_valid", 64'(mb.valid), 64'd0);
    check("rst_m_addr", mb.addr, 64'd0);
    check("rst_m_wstrb", 64'(mb.wstrb), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    sb.valid = 1'b0;
    @(negedge clk) resetn = 1'b1;
    repeat (2) @(negedge clk);
    cpu_rd("status_rst", ADDR_CTRL + 8, d);
    check("status_rst", d, 64'd0);
    cpu_rd("src_rst", ADDR_CTRL, d);
    check("src_rst", d, 64'd0);
    cpu_access(ADDR_CTRL + 12, 32'h1, 4'hF, d, ok);
    check("undecoded_above", 64'(ok), 64'd0);
    cpu_access(ADDR_CTRL - 4, 32'h1, 4'hF, d, ok);
    check("undecoded_below", 64'(ok), 64'd0);
    cpu_wr("src_lowbits", ADDR_CTRL, 32'h1234_5677);
    cpu_rd("src_lowbits", ADDR_CTRL, d);
    check("src_lowbits", d, 64'h1234_5674);

    // 2: A all ones, B column c all (c+1), plain copy
    ram[32'h1000] = 32'h0101_0101;
    ram[32'h1004] = 32'h0101_0101;
    for (int c = 0; c < 8; c++) begin
      ram[32'h1008 + 32'(8*c)] = {4{8'(c + 1)}};
      ram[32'h100C + 32'(8*c)] = {4{8'(c + 1)}};
    end
    for (int j = 0; j < NRS; j++) ram[32'h2000 + 32'(4*j)] = 32'h0;
    run_job("t2", 32'h1000, 32'h2000, 1'b0);
    check("t2_dst0", rd_ram(32'h2000), 64'h0010_0008);
    check("t2_dst1", rd_ram(32'h2004), 64'h0020_0018);
    check("t2_dst2", rd_ram(32'h2008), 64'h0030_0028);
    check("t2_dst3", rd_ram(32'h200C), 64'h0040_0038);
    n = 0;
    foreach (log_q[i]) if (log_q[i].we && log_q[i].addr == ACC_W + 32'(4*n)) n++;
    check("t2_acc_writes_in_order", 64'(n), 64'(NLD));

    // 3: accumulate with per-lane wrap
    ram[32'h2000] = 32'hFFFF_0001;
    for (int j = 1; j < NRS; j++) ram[32'h2000 + 32'(4*j)] = 32'h0;
    run_job("t3", 32'h1000, 32'h2000, 1'b1);
    check("t3_dst0_wrap", rd_ram(32'h2000), 64'h000F_0009);

    // 4: random data, random ready latency 0..5
    max_lat = 5;
    for (int t = 0; t < 4; t++) begin
      src = 32'h0001_0000 + 32'(t * 32'h100);
      dst = 32'h0002_0000 + 32'(t * 32'h40);
      for (int i = 0; i < NLD; i++) ram[src + 32'(4*i)] = $urandom;
      for (int j = 0; j < NRS; j++) ram[dst + 32'(4*j)] = $urandom;
      run_job("t4", src, dst, 1'($urandom_range(1)));
    end

    // 5: SRC write and start while busy are ignored
    max_lat = 3;
    for (int i = 0; i < NLD; i++) ram[32'h3000 + 32'(4*i)] = $urandom;
    for (int i = 0; i < NLD; i++) ram[32'h5000 + 32'(4*i)] = $urandom;
    cpu_wr("t5_src", ADDR_CTRL, 32'h3000);
    cpu_wr("t5_dst", ADDR_CTRL + 4, 32'h4000);
    prepare(32'h3000, 32'h4000, 1'b0);
    cpu_wr("t5_ctrl", ADDR_CTRL + 8, 32'h1);
    repeat (10) @(negedge clk);
    cpu_rd("t5_status_busy", ADDR_CTRL + 8, d);
    check("t5_status_busy", d, 64'h1);
    cpu_wr("t5_src_busy", ADDR_CTRL, 32'h5000);
    cpu_wr("t5_start_busy", ADDR_CTRL + 8, 32'h3);
    cpu_rd("t5_src_kept", ADDR_CTRL, d);
    check("t5_src_kept", d, 64'h3000);
    wait_idle("t5");
    verify("t5", 32'h4000, 1'b0);

    // 6: reset during the load phase, then a fresh job
    max_lat = 1;
    for (int i = 0; i < NLD; i++) ram[32'h6000 + 32'(4*i)] = $urandom;
    cpu_wr("t6_src", ADDR_CTRL, 32'h6000);
    cpu_wr("t6_dst", ADDR_CTRL + 4, 32'h7000);
    log_q.delete();
    cpu_wr("t6_ctrl", ADDR_CTRL + 8, 32'h1);
    n = 0;
    while (log_q.size() < 10 && n < 2000) begin @(negedge clk); n++; end
    check("t6_reach_beat10", 64'(n < 2000), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    check("t6_rst_m_valid", 64'(mb.valid), 64'd0);
    check("t6_rst_busy", 64'(busy), 64'd0);
    n = log_q.size();
    repeat (3) @(negedge clk);
    check("t6_no_beats_in_reset", 64'(log_q.size()), 64'(n));
    resetn = 1'b1;
    @(negedge clk);
    cpu_rd("t6_status_after", ADDR_CTRL + 8, d);
    check("t6_status_after", d, 64'd0);
    run_job("t6", 32'h6000, 32'h7000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
